// File: rtl/kf_bus_pkg.sv
// Shared types and helpers for the KF-series bus control unit.
//   bus_state_t : access tracking states (IDLE, WRITE, READ)
//   num_regs()  : number of decoded register slots for a given address width
//   onehot()    : address to one-hot decode, sized for the widest supported bus
package kf_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } bus_state_t;

  // Widest address bus the one-hot helper covers; callers size-cast the result.
  localparam int MAX_ADDR_WIDTH = 8;
  localparam int MAX_REGS       = 1 << MAX_ADDR_WIDTH;

  function automatic int num_regs(input int addr_width);
    return 1 << addr_width;
  endfunction

  function automatic logic [MAX_REGS-1:0] onehot(input logic [MAX_ADDR_WIDTH-1:0] addr);
    logic [MAX_REGS-1:0] vec;
    vec       = '0;
    vec[addr] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/kf_bus_control_unit_synchronizer.sv
// Input synchroniser for the board bus signals.
//   clock, reset : system clock, asynchronous active-high reset
//   async_in     : raw bus inputs (WIDTH bits)
//   sync_out     : inputs after SYNC_STAGES flops (direct when SYNC_STAGES = 0)
// RESET_VALUE gives each bit its own reset level so active-low strobes come
// out of reset deasserted.
module kf_bus_input_synchronizer #(
  parameter int               WIDTH       = 1,
  parameter int               SYNC_STAGES = 0,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out
);

  // At least one flop is declared so the chain is well formed; with
  // SYNC_STAGES = 0 it is bypassed and trimmed by synthesis.
  localparam int DEPTH = (SYNC_STAGES == 0) ? 1 : SYNC_STAGES;

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= RESET_VALUE;
    end else begin
      stage_q[0] <= async_in;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign sync_out = (SYNC_STAGES == 0) ? async_in : stage_q[DEPTH-1];

endmodule

// File: rtl/kf_bus_control_unit.sv
// Data-bus buffer and read/write control for KF-series peripherals.
//   clock, reset        : system clock, asynchronous active-high reset
//   chip_select_n       : CS#, active low
//   read_enable_n       : RD#, active low
//   write_enable_n      : WR#, active low
//   address             : register address (ADDR_WIDTH bits)
//   data_bus_in         : CPU write data
//   read_data           : register read values, slot i at [i*DATA_WIDTH +: DATA_WIDTH]
//   internal_data_bus   : captured write data, held until the next write
//   write_strobe        : one-hot, one cycle, on the trailing edge of WR#
//   read_active         : one-hot level for the duration of a read
//   read_end_strobe     : one-hot, one cycle, when a read completes
//   data_bus_out        : read data latched at the start of the read
//   data_bus_out_enable : external tristate drive enable
//   bus_busy            : high while an access is being tracked
module kf_bus_control_unit
  import kf_bus_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 2,
  parameter int SYNC_STAGES = 0
) (
  input  logic                                       clock,
  input  logic                                       reset,
  input  logic                                       chip_select_n,
  input  logic                                       read_enable_n,
  input  logic                                       write_enable_n,
  input  logic [ADDR_WIDTH-1:0]                      address,
  input  logic [DATA_WIDTH-1:0]                      data_bus_in,
  input  logic [num_regs(ADDR_WIDTH)*DATA_WIDTH-1:0] read_data,
  output logic [DATA_WIDTH-1:0]                      internal_data_bus,
  output logic [num_regs(ADDR_WIDTH)-1:0]            write_strobe,
  output logic [num_regs(ADDR_WIDTH)-1:0]            read_active,
  output logic [num_regs(ADDR_WIDTH)-1:0]            read_end_strobe,
  output logic [DATA_WIDTH-1:0]                      data_bus_out,
  output logic                                       data_bus_out_enable,
  output logic                                       bus_busy
);

  localparam int NUM_REGS = num_regs(ADDR_WIDTH);
  localparam int SYNC_W   = 3 + ADDR_WIDTH + DATA_WIDTH;
  // Strobes reset deasserted (high); address and data reset to zero.
  localparam logic [SYNC_W-1:0] SYNC_RESET = {3'b111, {(ADDR_WIDTH + DATA_WIDTH){1'b0}}};

  logic [SYNC_W-1:0]     sync_vec;
  logic                  s_cs, s_rd, s_wr;
  logic [ADDR_WIDTH-1:0] s_addr;
  logic [DATA_WIDTH-1:0] s_data;

  // ---- synchroniser stage ----
  kf_bus_input_synchronizer #(
    .WIDTH       (SYNC_W),
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VALUE (SYNC_RESET)
  ) u_sync (
    .clock    (clock),
    .reset    (reset),
    .async_in ({chip_select_n, read_enable_n, write_enable_n, address, data_bus_in}),
    .sync_out (sync_vec)
  );

  assign {s_cs, s_rd, s_wr, s_addr, s_data} = sync_vec;

  // ---- access tracking FSM and registered outputs ----
  bus_state_t            state_q, state_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic [DATA_WIDTH-1:0] idb_d, dbo_d;
  logic [NUM_REGS-1:0]   ws_d, ra_d, re_d;
  logic                  en_d, busy_d;
  logic [DATA_WIDTH-1:0] read_slot;

  assign read_slot = read_data[int'(s_addr)*DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    state_d = state_q;
    waddr_d = waddr_q;
    raddr_d = raddr_q;
    idb_d   = internal_data_bus;
    dbo_d   = data_bus_out;
    ws_d    = '0;
    re_d    = '0;
    ra_d    = read_active;
    en_d    = data_bus_out_enable;
    case (state_q)
      IDLE: begin
        // Write takes priority when RD# and WR# are both low.
        if (!s_cs && !s_wr) begin
          state_d = WRITE;
          idb_d   = s_data;
          waddr_d = s_addr;
        end else if (!s_cs && !s_rd) begin
          state_d = READ;
          dbo_d   = read_slot;
          raddr_d = s_addr;
          ra_d    = NUM_REGS'(onehot(MAX_ADDR_WIDTH'(s_addr)));
          en_d    = 1'b1;
        end
      end
      WRITE: begin
        if (s_cs) begin
          // CS# lost before WR# completed: drop the access silently.
          state_d = IDLE;
        end else if (s_wr) begin
          state_d = IDLE;
          ws_d    = NUM_REGS'(onehot(MAX_ADDR_WIDTH'(waddr_q)));
        end else begin
          idb_d   = s_data;
          waddr_d = s_addr;
        end
      end
      READ: begin
        // Either strobe ending the read completes it, so side effects always fire.
        if (s_rd || s_cs) begin
          state_d = IDLE;
          re_d    = NUM_REGS'(onehot(MAX_ADDR_WIDTH'(raddr_q)));
          ra_d    = '0;
          en_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q             <= IDLE;
      waddr_q             <= '0;
      raddr_q             <= '0;
      internal_data_bus   <= '0;
      data_bus_out        <= '0;
      write_strobe        <= '0;
      read_active         <= '0;
      read_end_strobe     <= '0;
      data_bus_out_enable <= 1'b0;
      bus_busy            <= 1'b0;
    end else begin
      state_q             <= state_d;
      waddr_q             <= waddr_d;
      raddr_q             <= raddr_d;
      internal_data_bus   <= idb_d;
      data_bus_out        <= dbo_d;
      write_strobe        <= ws_d;
      read_active         <= ra_d;
      read_end_strobe     <= re_d;
      data_bus_out_enable <= en_d;
      bus_busy            <= busy_d;
    end
  end

endmodule

// File: tb/tb_kf_bus_control_unit.sv
module tb_kf_bus_control_unit;

  localparam int W = 14;
  localparam int K_WRITE = 0;
  localparam int K_READ  = 1;
  localparam int K_ABORT = 2;
  localparam int K_SIMUL = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cs_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1;
  logic [2:0]  address = '0;
  logic [7:0]  data_in = '0;
  logic [31:0] read_data0 = '0;
  logic [63:0] read_data1 = '0;

  logic [7:0] idb0, dbo0, idb1, dbo1;
  logic [3:0] ws0, ra0, re0;
  logic [7:0] ws1, ra1, re1;
  logic       en0, busy0, en1, busy1;

  always #5 clock = ~clock;

  kf_bus_control_unit #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .SYNC_STAGES(0)) dut0 (
    .clock(clock), .reset(reset), .chip_select_n(cs_n), .read_enable_n(rd_n),
    .write_enable_n(wr_n), .address(address[1:0]), .data_bus_in(data_in),
    .read_data(read_data0), .internal_data_bus(idb0), .write_strobe(ws0),
    .read_active(ra0), .read_end_strobe(re0), .data_bus_out(dbo0),
    .data_bus_out_enable(en0), .bus_busy(busy0));

  kf_bus_control_unit #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .SYNC_STAGES(2)) dut1 (
    .clock(clock), .reset(reset), .chip_select_n(cs_n), .read_enable_n(rd_n),
    .write_enable_n(wr_n), .address(address), .data_bus_in(data_in),
    .read_data(read_data1), .internal_data_bus(idb1), .write_strobe(ws1),
    .read_active(ra1), .read_end_strobe(re1), .data_bus_out(dbo1),
    .data_bus_out_enable(en1), .bus_busy(busy1));

  int total = 0;
  int bad = 0;
  int k;

  logic [7:0] ws_log [2][W+1];
  logic [7:0] re_log [2][W+1];
  logic [7:0] ra_log [2][W+1];
  logic [7:0] dbo_log [2][W+1];
  logic [7:0] idb_log [2][W+1];
  logic       en_log [2][W+1];
  logic       busy_log [2][W+1];

  // Reference state: last committed/captured values seen by the peripheral side.
  logic [7:0] idb_exp [2];
  logic [7:0] dbo_exp [2];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: sample just after the rising edge, return at the falling edge
  // where the next pin values are driven.
  task automatic tick();
    @(posedge clock);
    #1;
    if (k <= W) begin
      ws_log[0][k]   = {4'b0, ws0};  ws_log[1][k]   = ws1;
      re_log[0][k]   = {4'b0, re0};  re_log[1][k]   = re1;
      ra_log[0][k]   = {4'b0, ra0};  ra_log[1][k]   = ra1;
      dbo_log[0][k]  = dbo0;         dbo_log[1][k]  = dbo1;
      idb_log[0][k]  = idb0;         idb_log[1][k]  = idb1;
      en_log[0][k]   = en0;          en_log[1][k]   = en1;
      busy_log[0][k] = busy0;        busy_log[1][k] = busy1;
    end
    k++;
    @(negedge clock);
  endtask

  // Drives one bus access and checks both DUTs tick by tick. The pins go
  // active before tick 1 and inactive after tick len; a unit with S
  // synchroniser stages is busy for ticks S+1..len+S and reports the end
  // (strobe) on tick len+S+1.
  task automatic do_access(input int kind, input logic [2:0] a, input logic [7:0] d,
                           input int len, input bit alt);
    logic [31:0] rd0;
    logic [63:0] rd1;
    logic [7:0]  dfinal;
    logic [7:0]  dbo_new [2];
    logic [7:0]  oh;
    int          s;
    bit          in_span, at_end, is_wr;
    rd0 = $urandom;
    rd1 = {$urandom, $urandom};
    dbo_new[0] = rd0[int'(a[1:0])*8 +: 8];
    dbo_new[1] = rd1[int'(a)*8 +: 8];
    dfinal = d;
    k = 1;
    address = a; data_in = d; read_data0 = rd0; read_data1 = rd1;
    case (kind)
      K_WRITE: begin
        cs_n = 1'b0; wr_n = 1'b0;
        for (int i = 1; i <= len; i++) begin
          tick();
          if (i == 1 && len >= 2 && alt) begin
            dfinal  = d ^ 8'h3c;
            data_in = dfinal;
          end
        end
        wr_n = 1'b1; tick(); cs_n = 1'b1;
      end
      K_READ: begin
        cs_n = 1'b0; rd_n = 1'b0;
        for (int i = 1; i <= len; i++) begin
          tick();
          if (i == 3) begin
            read_data0 = ~rd0; read_data1 = ~rd1; address = ~a;
          end
        end
        if (alt) cs_n = 1'b1; else rd_n = 1'b1;
        tick(); cs_n = 1'b1; rd_n = 1'b1;
      end
      K_ABORT: begin
        cs_n = 1'b0; wr_n = 1'b0;
        repeat (len) tick();
        cs_n = 1'b1;
        if (!alt) wr_n = 1'b1;
        tick(); wr_n = 1'b1;
      end
      default: begin
        cs_n = 1'b0; rd_n = 1'b0; wr_n = 1'b0;
        repeat (len) tick();
        rd_n = 1'b1; wr_n = 1'b1; tick(); cs_n = 1'b1;
      end
    endcase
    while (k <= W) tick();

    is_wr = (kind == K_WRITE) || (kind == K_SIMUL);
    for (int u = 0; u < 2; u++) begin
      s  = (u == 0) ? 0 : 2;
      oh = (u == 0) ? (8'd1 << a[1:0]) : (8'd1 << a);
      if (kind != K_READ) idb_exp[u] = dfinal;
      else                dbo_exp[u] = dbo_new[u];
      for (int t = 1; t <= W; t++) begin
        in_span = (t >= s + 1) && (t <= len + s);
        at_end  = (t == len + s + 1);
        check_val($sformatf("wstrobe u%0d k%0d t%0d", u, kind, t), 64'(ws_log[u][t]),
                  (is_wr && at_end) ? 64'(oh) : 64'd0);
        check_val($sformatf("rend u%0d k%0d t%0d", u, kind, t), 64'(re_log[u][t]),
                  (kind == K_READ && at_end) ? 64'(oh) : 64'd0);
        check_val($sformatf("ractive u%0d k%0d t%0d", u, kind, t), 64'(ra_log[u][t]),
                  (kind == K_READ && in_span) ? 64'(oh) : 64'd0);
        check_val($sformatf("oe u%0d k%0d t%0d", u, kind, t), 64'(en_log[u][t]),
                  64'(kind == K_READ && in_span));
        check_val($sformatf("busy u%0d k%0d t%0d", u, kind, t), 64'(busy_log[u][t]),
                  64'(in_span));
        if (kind == K_READ && t >= s + 1)
          check_val($sformatf("dbo_hold u%0d t%0d", u, t), 64'(dbo_log[u][t]), 64'(dbo_new[u]));
      end
      check_val($sformatf("idb u%0d k%0d", u, kind), 64'(idb_log[u][W]), 64'(idb_exp[u]));
      check_val($sformatf("dbo u%0d k%0d", u, kind), 64'(dbo_log[u][W]), 64'(dbo_exp[u]));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, " ws0"},   64'(ws0),   64'd0);
    check_val({tag, " ws1"},   64'(ws1),   64'd0);
    check_val({tag, " ra0"},   64'(ra0),   64'd0);
    check_val({tag, " ra1"},   64'(ra1),   64'd0);
    check_val({tag, " re0"},   64'(re0),   64'd0);
    check_val({tag, " re1"},   64'(re1),   64'd0);
    check_val({tag, " idb0"},  64'(idb0),  64'd0);
    check_val({tag, " idb1"},  64'(idb1),  64'd0);
    check_val({tag, " dbo0"},  64'(dbo0),  64'd0);
    check_val({tag, " dbo1"},  64'(dbo1),  64'd0);
    check_val({tag, " en0"},   64'(en0),   64'd0);
    check_val({tag, " en1"},   64'(en1),   64'd0);
    check_val({tag, " busy0"}, 64'(busy0), 64'd0);
    check_val({tag, " busy1"}, 64'(busy1), 64'd0);
  endtask

  initial begin
    int kind, len;
    idb_exp[0] = '0; idb_exp[1] = '0;
    dbo_exp[0] = '0; dbo_exp[1] = '0;

    repeat (2) @(negedge clock);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clock);

    // Directed cases from the intended use.
    do_access(K_WRITE, 3'd2, 8'hA5, 3, 1'b0);
    do_access(K_READ,  3'd1, 8'h00, 5, 1'b0);
    do_access(K_READ,  3'd6, 8'h00, 4, 1'b1);
    do_access(K_ABORT, 3'd0, 8'h11, 2, 1'b1);
    do_access(K_ABORT, 3'd4, 8'h22, 3, 1'b0);
    do_access(K_SIMUL, 3'd3, 8'h5A, 2, 1'b0);
    do_access(K_WRITE, 3'd7, 8'hC3, 1, 1'b0);
    do_access(K_WRITE, 3'd5, 8'h96, 4, 1'b1);

    // Reset in the middle of a write.
    k = 1;
    cs_n = 1'b0; wr_n = 1'b0; address = 3'd5; data_in = 8'h77;
    repeat (4) tick();
    reset = 1'b1; cs_n = 1'b1; wr_n = 1'b1;
    #1;
    check_all_zero("midrst");
    idb_exp[0] = '0; idb_exp[1] = '0;
    dbo_exp[0] = '0; dbo_exp[1] = '0;
    @(negedge clock);
    reset = 1'b0;
    k = 1;
    while (k <= W) tick();
    for (int u = 0; u < 2; u++) begin
      for (int t = 1; t <= W; t++) begin
        check_val($sformatf("postrst ws u%0d t%0d", u, t), 64'(ws_log[u][t]), 64'd0);
        check_val($sformatf("postrst busy u%0d t%0d", u, t), 64'(busy_log[u][t]), 64'd0);
      end
      check_val($sformatf("postrst idb u%0d", u), 64'(idb_log[u][W]), 64'd0);
    end
    do_access(K_WRITE, 3'd2, 8'h3E, 2, 1'b0);

    // Randomized accesses.
    for (int n = 0; n < 30; n++) begin
      kind = int'($urandom_range(0, 3));
      len  = (kind == K_READ) ? int'($urandom_range(4, 6)) : int'($urandom_range(1, 6));
      do_access(kind, 3'($urandom), 8'($urandom), len, 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
